hqm_aw_if_prot_seq: RTL and testbench
=====================================

// Module: hqm_AW_if_prot_seq
// PURPOSE
//  Sequenced, parametrised interface protection for FLR. Replaces per-signal combinational
//  clamps with one NUM_CH-wide block that drains in-flight activity before clamping.
//  Sits between a unit's control outputs and the neighbouring unit. Channels clamp individually
//  once idle; a watchdog forces full isolation. Release is delayed so the peer sees clean edges.
// PARAMETERS
//  NUM_CH        4  number of protected control bits (>=1)
//  CLAMP_VAL     '0 NUM_CH-bit value driven on each channel while clamped
//  DRAIN_TIMEOUT 16 max DRAIN cycles before forced clamp; 0 = no timeout
//  RELEASE_DLY   2  cycles outputs stay clamped after flr_prep deasserts (>=1)
// PORTS
//  clk              in  1       unit clock
//  rst_n            in  1       asynchronous active-low reset
//  flr_prep         in  1       FLR preparation request, level, synchronous to clk
//  in_data          in  NUM_CH  unprotected control bits
//  in_busy          in  NUM_CH  per-channel transaction-in-flight indicator
//  clr_timeout      in  1       clears drain_timeout_sticky
//  out_data         out NUM_CH  protected control bits
//  iso_active       out 1       1 in ISOLATED and RELEASE
//  drain_done       out 1       1-cycle pulse on entry to ISOLATED
//  drain_timeout_sticky out 1   set when watchdog forced the clamp
// BEHAVIOUR
//  - Reset: state IDLE, clamp_mask=0, cnt=0; out_data=in_data, iso_active=0, drain_done=0,
//    sticky=0. Reset asserted mid-sequence returns to IDLE immediately (pass-through).
//  - out_data[i] = clamp_mask[i] ? CLAMP_VAL[i] : in_data[i]; combinational from in_data, no latency.
//  - FSM (registered, one transition per cycle):
//    IDLE:     flr_prep=1 -> DRAIN, cnt=0.
//    DRAIN:    each cycle clamp_mask |= ~in_busy (channel clamps the cycle after busy seen low;
//              mask bits never clear in DRAIN). cnt++ (saturating).
//              if (clamp_mask|~in_busy)==all-1 -> ISOLATED, drain_done=1 next cycle.
//              else if DRAIN_TIMEOUT!=0 && cnt==DRAIN_TIMEOUT-1 -> clamp_mask=all-1, sticky=1, ISOLATED.
//              flr_prep=0 -> RELEASE (priority over completion/timeout), cnt=0.
//    ISOLATED: clamp_mask all-1; flr_prep=0 -> RELEASE, cnt=0.
//    RELEASE:  clamp_mask held; cnt++; cnt==RELEASE_DLY-1 -> IDLE, clamp_mask=0.
//              flr_prep=1 -> DRAIN, cnt=0, clamp_mask retained (no unclamp glitch).
//  - drain_done: asserted exactly one cycle, the first cycle state==ISOLATED; never on re-entry
//    without passing DRAIN.
//  - Sticky: set on timeout; cleared by clr_timeout when no set same cycle (set wins).
//  - cnt width $clog2(max(DRAIN_TIMEOUT,RELEASE_DLY)+1); never wraps.
//  - in_busy ignored in IDLE, ISOLATED, RELEASE. in_busy rising on a clamped channel does not unclamp.
// STRUCTURE
//  - hqm_AW_if_prot_pkg: state enum (IDLE, DRAIN, ISOLATED, RELEASE), 2-bit encoding.
//  - Sub-module hqm_AW_if_prot_ch_clamp: per-channel mask flop + output mux, generated NUM_CH times.
//  - Top holds FSM, counter, sticky, drain_done flop.
// TESTING
//  1 NUM_CH=4, busy=0, flr_prep 0->1 -> clamp after 1 cycle, ISOLATED, drain_done 1 pulse, sticky=0.
//  2 busy=4'b0110, drop bit1 at cyc3, bit2 at cyc5 -> mask 1001,1011,1111; ISOLATED cyc6.
//  3 busy=4'b0001 held, DRAIN_TIMEOUT=16 -> forced clamp after 16 DRAIN cycles, sticky=1, drain_done pulse.
//  4 ISOLATED, flr_prep->0 -> out clamped 2 more cycles (RELEASE_DLY=2), then out_data==in_data.
//  5 RELEASE, flr_prep->1 -> DRAIN, outputs never unclamp; clr_timeout+timeout same cycle -> sticky=1.
//  6 rst_n low mid-DRAIN -> IDLE, out_data==in_data, all status outputs 0 asynchronously.

Source files
------------

// File: rtl/hqm_aw_if_prot_seq_pkg.sv
// Shared types for the sequenced interface-protection block: FSM state encoding
// and a small constant helper used for sizing the drain/release counter.
package hqm_aw_if_prot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2,
    ST_RELEASE  = 2'd3
  } prot_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hqm_aw_if_prot_seq_ch_clamp.sv
// One protected channel: clamp-mask flop plus the output mux selecting the
// clamp value or the live input bit.
module hqm_aw_if_prot_seq_ch_clamp (
  input  logic clk,
  input  logic rst_n,
  input  logic mask_next,
  input  logic clamp_val,
  input  logic in_bit,
  output logic mask,
  output logic out_bit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= 1'b0;
    end else begin
      mask <= mask_next;
    end
  end

  // Pass-through has no latency; only the select is registered.
  assign out_bit = mask ? clamp_val : in_bit;

endmodule

// File: rtl/hqm_aw_if_prot_seq.sv
// FLR interface protection: drains per-channel activity, clamps idle channels,
// forces isolation on watchdog expiry and delays release for clean edges.
module hqm_aw_if_prot_seq
  import hqm_aw_if_prot_seq_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter logic [NUM_CH-1:0] CLAMP_VAL     = '0,
  parameter int                DRAIN_TIMEOUT = 16,
  parameter int                RELEASE_DLY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flr_prep,
  input  logic [NUM_CH-1:0] in_data,
  input  logic [NUM_CH-1:0] in_busy,
  input  logic              clr_timeout,
  output logic [NUM_CH-1:0] out_data,
  output logic              iso_active,
  output logic              drain_done,
  output logic              drain_timeout_sticky
);

  localparam int CW = $clog2(max_int(DRAIN_TIMEOUT, RELEASE_DLY) + 1);

  prot_state_t       state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next, cnt_inc;
  logic              sticky_reg, sticky_next;
  logic              drain_done_reg, drain_done_next;
  logic              timeout_set;
  logic [NUM_CH-1:0] clamp_mask, mask_next, mask_or;

  assign mask_or = clamp_mask | ~in_busy;
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    mask_next       = clamp_mask;
    drain_done_next = 1'b0;
    timeout_set     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (flr_prep) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end
      end
      ST_DRAIN: begin
        mask_next = mask_or;
        cnt_next  = cnt_inc;
        // Withdrawal of the request outranks both completion and the watchdog.
        if (!flr_prep) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end else if (&mask_or) begin
          state_next      = ST_ISOLATED;
          drain_done_next = 1'b1;
        end else if ((DRAIN_TIMEOUT != 0) && (cnt_reg == CW'(DRAIN_TIMEOUT - 1))) begin
          state_next      = ST_ISOLATED;
          mask_next       = '1;
          timeout_set     = 1'b1;
          drain_done_next = 1'b1;
        end
      end
      ST_ISOLATED: begin
        mask_next = '1;
        if (!flr_prep) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end
      end
      ST_RELEASE: begin
        cnt_next = cnt_inc;
        // Re-request keeps the mask so the peer never sees an unclamp glitch.
        if (flr_prep) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(RELEASE_DLY - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          mask_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        mask_next  = '0;
        cnt_next   = '0;
      end
    endcase
    sticky_next = timeout_set ? 1'b1 : (clr_timeout ? 1'b0 : sticky_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      sticky_reg     <= 1'b0;
      drain_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      sticky_reg     <= sticky_next;
      drain_done_reg <= drain_done_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      hqm_aw_if_prot_seq_ch_clamp u_clamp (
        .clk       (clk),
        .rst_n     (rst_n),
        .mask_next (mask_next[gi]),
        .clamp_val (CLAMP_VAL[gi]),
        .in_bit    (in_data[gi]),
        .mask      (clamp_mask[gi]),
        .out_bit   (out_data[gi])
      );
    end
  endgenerate

  assign iso_active           = (state_reg == ST_ISOLATED) || (state_reg == ST_RELEASE);
  assign drain_done           = drain_done_reg;
  assign drain_timeout_sticky = sticky_reg;

endmodule

// File: tb/tb_hqm_aw_if_prot_seq.sv
// Directed bench for hqm_aw_if_prot_seq with CLAMP_VAL=4'b0101 and in_data=4'b1010
// so every clamped bit is distinguishable from its pass-through value.
module tb_hqm_aw_if_prot_seq;

  localparam logic [3:0] CV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flr_prep = 1'b0;
  logic [3:0] in_data = 4'b1010;
  logic [3:0] in_busy = 4'b0000;
  logic       clr_timeout = 1'b0;
  logic [3:0] out_data;
  logic       iso_active;
  logic       drain_done;
  logic       drain_timeout_sticky;

  int pass_cnt = 0;
  int total_cnt = 0;

  hqm_aw_if_prot_seq #(
    .NUM_CH        (4),
    .CLAMP_VAL     (CV),
    .DRAIN_TIMEOUT (16),
    .RELEASE_DLY   (2)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flr_prep             (flr_prep),
    .in_data              (in_data),
    .in_busy              (in_busy),
    .clr_timeout          (clr_timeout),
    .out_data             (out_data),
    .iso_active           (iso_active),
    .drain_done           (drain_done),
    .drain_timeout_sticky (drain_timeout_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL rst_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL rst_iso: got %b exp 0", iso_active); else pass_cnt++;
    total_cnt++; if (drain_done !== 1'b0) $display("FAIL rst_dd: got %b exp 0", drain_done); else pass_cnt++;
    total_cnt++; if (drain_timeout_sticky !== 1'b0) $display("FAIL rst_sticky: got %b exp 0", drain_timeout_sticky); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    in_data = 4'b0110;
    #1;
    total_cnt++; if (out_data !== 4'b0110) $display("FAIL idle_pass: got %b exp %b", out_data, 4'b0110); else pass_cnt++;
    in_data = 4'b1010;
    $display("test_reset done");
  endtask

  task automatic test_idle_drain();
    in_busy = 4'b0000;
    flr_prep = 1'b1;
    tick();  // DRAIN, nothing clamped yet
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL t1_drain_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL t1_drain_iso: got %b exp 0", iso_active); else pass_cnt++;
    tick();  // ISOLATED
    total_cnt++; if (out_data !== CV) $display("FAIL t1_iso_out: got %b exp %b", out_data, CV); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b1) $display("FAIL t1_iso_iso: got %b exp 1", iso_active); else pass_cnt++;
    total_cnt++; if (drain_done !== 1'b1) $display("FAIL t1_dd_pulse: got %b exp 1", drain_done); else pass_cnt++;
    tick();
    total_cnt++; if (drain_done !== 1'b0) $display("FAIL t1_dd_end: got %b exp 0", drain_done); else pass_cnt++;
    total_cnt++; if (drain_timeout_sticky !== 1'b0) $display("FAIL t1_sticky: got %b exp 0", drain_timeout_sticky); else pass_cnt++;
    $display("test_idle_drain done");
  endtask

  task automatic test_release();
    flr_prep = 1'b0;
    tick();  // RELEASE cnt0
    total_cnt++; if (out_data !== CV) $display("FAIL t4_rel0_out: got %b exp %b", out_data, CV); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b1) $display("FAIL t4_rel0_iso: got %b exp 1", iso_active); else pass_cnt++;
    tick();  // RELEASE cnt1
    total_cnt++; if (out_data !== CV) $display("FAIL t4_rel1_out: got %b exp %b", out_data, CV); else pass_cnt++;
    tick();  // IDLE
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL t4_idle_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL t4_idle_iso: got %b exp 0", iso_active); else pass_cnt++;
    $display("test_release done");
  endtask

  task automatic test_per_channel();
    in_busy = 4'b0110;
    flr_prep = 1'b1;
    tick();  // DRAIN cyc1, mask 0000
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL t2_c1_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    tick();  // mask 1001
    total_cnt++; if (out_data !== 4'b0011) $display("FAIL t2_c2_out: got %b exp %b", out_data, 4'b0011); else pass_cnt++;
    tick();  // cyc3: drop bit1, raise bit0 on an already clamped channel
    in_busy = 4'b0101;
    tick();  // mask 1011
    total_cnt++; if (out_data !== 4'b0001) $display("FAIL t2_c4_out: got %b exp %b", out_data, 4'b0001); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL t2_c4_iso: got %b exp 0", iso_active); else pass_cnt++;
    tick();  // cyc5: drop bit2
    in_busy = 4'b0001;
    tick();  // ISOLATED cyc6
    total_cnt++; if (out_data !== CV) $display("FAIL t2_iso_out: got %b exp %b", out_data, CV); else pass_cnt++;
    total_cnt++; if (drain_done !== 1'b1) $display("FAIL t2_dd: got %b exp 1", drain_done); else pass_cnt++;
    flr_prep = 1'b0;
    in_busy = 4'b0000;
    repeat (3) tick();
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL t2_idle_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    $display("test_per_channel done");
  endtask

  task automatic test_timeout();
    in_busy = 4'b0001;
    flr_prep = 1'b1;
    repeat (16) tick();  // DRAIN cnt15, channel 0 still busy
    total_cnt++; if (out_data !== 4'b0100) $display("FAIL t3_pre_out: got %b exp %b", out_data, 4'b0100); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL t3_pre_iso: got %b exp 0", iso_active); else pass_cnt++;
    total_cnt++; if (drain_timeout_sticky !== 1'b0) $display("FAIL t3_pre_sticky: got %b exp 0", drain_timeout_sticky); else pass_cnt++;
    tick();  // forced ISOLATED
    total_cnt++; if (out_data !== CV) $display("FAIL t3_iso_out: got %b exp %b", out_data, CV); else pass_cnt++;
    total_cnt++; if (drain_timeout_sticky !== 1'b1) $display("FAIL t3_sticky: got %b exp 1", drain_timeout_sticky); else pass_cnt++;
    total_cnt++; if (drain_done !== 1'b1) $display("FAIL t3_dd: got %b exp 1", drain_done); else pass_cnt++;
    tick();
    total_cnt++; if (drain_timeout_sticky !== 1'b1) $display("FAIL t3_sticky_hold: got %b exp 1", drain_timeout_sticky); else pass_cnt++;
    clr_timeout = 1'b1;
    tick();
    clr_timeout = 1'b0;
    total_cnt++; if (drain_timeout_sticky !== 1'b0) $display("FAIL t3_sticky_clr: got %b exp 0", drain_timeout_sticky); else pass_cnt++;
    $display("test_timeout done");
  endtask

  task automatic test_rerequest();
    flr_prep = 1'b0;
    tick();  // RELEASE cnt0
    flr_prep = 1'b1;
    tick();  // DRAIN with mask retained
    total_cnt++; if (out_data !== CV) $display("FAIL t5_redrain_out: got %b exp %b", out_data, CV); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL t5_redrain_iso: got %b exp 0", iso_active); else pass_cnt++;
    tick();  // ISOLATED again through DRAIN
    total_cnt++; if (out_data !== CV) $display("FAIL t5_reiso_out: got %b exp %b", out_data, CV); else pass_cnt++;
    total_cnt++; if (drain_done !== 1'b1) $display("FAIL t5_reiso_dd: got %b exp 1", drain_done); else pass_cnt++;
    flr_prep = 1'b0;
    repeat (3) tick();
    // Timeout while clr_timeout held: set must win.
    clr_timeout = 1'b1;
    flr_prep = 1'b1;
    repeat (17) tick();
    total_cnt++; if (drain_timeout_sticky !== 1'b1) $display("FAIL t5_set_wins: got %b exp 1", drain_timeout_sticky); else pass_cnt++;
    clr_timeout = 1'b0;
    tick();
    total_cnt++; if (drain_timeout_sticky !== 1'b1) $display("FAIL t5_sticky_hold: got %b exp 1", drain_timeout_sticky); else pass_cnt++;
    flr_prep = 1'b0;
    repeat (3) tick();
    $display("test_rerequest done");
  endtask

  task automatic test_async_reset();
    in_busy = 4'b0001;
    flr_prep = 1'b1;
    tick();
    tick();  // DRAIN, mask 1110
    total_cnt++; if (out_data !== 4'b0100) $display("FAIL t6_pre_out: got %b exp %b", out_data, 4'b0100); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL t6_rst_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    total_cnt++; if (iso_active !== 1'b0) $display("FAIL t6_rst_iso: got %b exp 0", iso_active); else pass_cnt++;
    total_cnt++; if (drain_done !== 1'b0) $display("FAIL t6_rst_dd: got %b exp 0", drain_done); else pass_cnt++;
    total_cnt++; if (drain_timeout_sticky !== 1'b0) $display("FAIL t6_rst_sticky: got %b exp 0", drain_timeout_sticky); else pass_cnt++;
    flr_prep = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (out_data !== 4'b1010) $display("FAIL t6_post_out: got %b exp %b", out_data, 4'b1010); else pass_cnt++;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_release();
    test_per_channel();
    test_timeout();
    test_rerequest();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
